// File: rtl/fairy_sram_pkg.sv
// Shared definitions for the fairy SRAM responder: FSM states, lane count and
// latency-counter width.
package fairy_sram_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam int NUM_LANES = 4;
  localparam int CNT_W     = 4;
  localparam logic [NUM_LANES-1:0] CEN_IDLE = 4'hF;

endpackage

// File: rtl/fairy_sram_if.sv
// Fairy SRAM port: request (cen/wr/addr/wdata) and response (ack/rrdy/rdata/busy).
interface fairy_sram_if;
  import fairy_sram_pkg::*;

  logic [NUM_LANES-1:0] sram_cen;
  logic                 sram_wr;
  logic [31:0]          sram_addr;
  logic [31:0]          sram_wdata;
  logic                 sram_ack;
  logic                 sram_rrdy;
  logic [31:0]          sram_rdata;
  logic                 busy;

  modport master (
    output sram_cen, sram_wr, sram_addr, sram_wdata,
    input  sram_ack, sram_rrdy, sram_rdata, busy
  );

  modport slave (
    input  sram_cen, sram_wr, sram_addr, sram_wdata,
    output sram_ack, sram_rrdy, sram_rdata, busy
  );

endinterface

// File: rtl/fairy_sram_array.sv
// Word storage with per-byte write enables and one registered read port that
// holds its value until the next read is issued.
module fairy_sram_array
  import fairy_sram_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [NUM_LANES-1:0] we,
  input  logic [31:0]          wdata,
  input  logic                 re,
  output logic [31:0]          rd_data
);

  logic [31:0] mem [2**ADDR_W];

  // NOTE: the storage array has no reset so it maps onto RAM macros; only the
  // read register below is reset.
  always_ff @(posedge aclk) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset)  rd_data <= '0;
    else if (re) rd_data <= mem[addr];
  end

endmodule

// File: rtl/fairy_sram_responder.sv
// Target side of the fairy SRAM port: accepts reads/writes, returns read data
// after READ_LATENCY cycles and refuses new requests while a long read is pending.
module fairy_sram_responder
  import fairy_sram_pkg::*;
#(
  parameter int ADDR_W       = 10,
  parameter int READ_LATENCY = 1
) (
  input logic         aclk,
  input logic         areset,
  fairy_sram_if.slave bus
);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ack_q;
  logic                 rrdy_q, rrdy_d;
  logic                 req, accept, rd_accept;
  logic [NUM_LANES-1:0] we;
  logic [ADDR_W-1:0]    word_idx;
  logic [31:0]          rd_data;
  logic                 unused_addr_bits;

  assign req       = (bus.sram_cen != CEN_IDLE);
  assign accept    = req & ((state_q == ST_IDLE) | rrdy_q);
  assign rd_accept = accept & ~bus.sram_wr;
  assign we        = ~bus.sram_cen & {NUM_LANES{accept & bus.sram_wr}};
  // Upper address bits alias onto the same words; byte offset is ignored.
  assign word_idx         = bus.sram_addr[ADDR_W+1:2];
  assign unused_addr_bits = ^{bus.sram_addr[31:ADDR_W+2], bus.sram_addr[1:0]};

  fairy_sram_array #(.ADDR_W(ADDR_W)) u_array (
    .aclk    (aclk),
    .areset  (areset),
    .addr    (word_idx),
    .we      (we),
    .wdata   (bus.sram_wdata),
    .re      (rd_accept),
    .rd_data (rd_data)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rrdy_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rd_accept) begin
          if (READ_LATENCY == 1) begin
            rrdy_d = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(READ_LATENCY - 1);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          rrdy_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      rrdy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= accept;
      rrdy_q  <= rrdy_d;
    end
  end

  // Single-cycle reads return straight from the array register; longer reads
  // copy it into a hold register at the response edge.
  if (READ_LATENCY == 1) begin : g_direct
    assign bus.sram_rdata = rd_data;
  end else begin : g_hold
    logic [31:0] rdata_q;
    always_ff @(posedge aclk or posedge areset) begin
      if (areset)      rdata_q <= '0;
      else if (rrdy_d) rdata_q <= rd_data;
    end
    assign bus.sram_rdata = rdata_q;
  end

  assign bus.sram_ack  = ack_q;
  assign bus.sram_rrdy = rrdy_q;
  assign bus.busy      = (state_q == ST_WAIT);

endmodule

// File: tb/tb_fairy_sram_responder.sv
// Bench for fairy_sram_responder: three instances (latency 1, 4, 3) checked every
// cycle against a cycle-number based reference model, plus directed scenarios.
module tb_fairy_sram_responder;
  import fairy_sram_pkg::*;

  localparam int ND = 3;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  logic [3:0]  cen_a   [ND];
  logic        wr_a    [ND];
  logic [31:0] addr_a  [ND];
  logic [31:0] wdata_a [ND];
  logic        ack_a   [ND];
  logic        rrdy_a  [ND];
  logic [31:0] rdata_a [ND];
  logic        busy_a  [ND];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int LAT_G = (g == 0) ? 1 : (g == 1) ? 4 : 3;
    fairy_sram_if u_if ();
    assign u_if.sram_cen   = cen_a[g];
    assign u_if.sram_wr    = wr_a[g];
    assign u_if.sram_addr  = addr_a[g];
    assign u_if.sram_wdata = wdata_a[g];
    assign ack_a[g]   = u_if.sram_ack;
    assign rrdy_a[g]  = u_if.sram_rrdy;
    assign rdata_a[g] = u_if.sram_rdata;
    assign busy_a[g]  = u_if.busy;
    fairy_sram_responder #(.ADDR_W(10), .READ_LATENCY(LAT_G)) u_dut (
      .aclk   (aclk),
      .areset (areset),
      .bus    (u_if)
    );
  end

  // Reference model: acceptance and response timing from cycle numbers.
  logic [31:0] mem_m [ND][1024];
  int          cyc = 0;
  int          next_free [ND] = '{0, 0, 0};
  bit          pend      [ND] = '{0, 0, 0};
  int          due       [ND] = '{0, 0, 0};
  logic [31:0] pval      [ND];
  bit          acc       [ND] = '{0, 0, 0};
  bit          exp_ack   [ND] = '{0, 0, 0};
  bit          exp_rrdy  [ND] = '{0, 0, 0};
  bit          exp_busy  [ND] = '{0, 0, 0};
  logic [31:0] exp_rdata [ND] = '{0, 0, 0};

  int n_cmp = 0;
  int n_fail = 0;

  function automatic int lat_of(int d);
    return (d == 0) ? 1 : (d == 1) ? 4 : 3;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [9:0] idx;
    for (int d = 0; d < ND; d++) begin
      acc[d] = 1'b0;
      if (areset) begin
        pend[d] = 1'b0; next_free[d] = 0;
        exp_ack[d] = 1'b0; exp_rrdy[d] = 1'b0; exp_busy[d] = 1'b0; exp_rdata[d] = '0;
      end else begin
        exp_ack[d]  = 1'b0;
        exp_rrdy[d] = 1'b0;
        if (cen_a[d] != CEN_IDLE && cyc >= next_free[d]) begin
          acc[d] = 1'b1;
          exp_ack[d] = 1'b1;
          idx = addr_a[d][11:2];
          if (wr_a[d]) begin
            for (int i = 0; i < 4; i++)
              if (!cen_a[d][i]) mem_m[d][idx][8*i +: 8] = wdata_a[d][8*i +: 8];
            next_free[d] = cyc + 1;
          end else begin
            pval[d] = mem_m[d][idx];
            pend[d] = 1'b1;
            due[d]  = cyc + lat_of(d);
            next_free[d] = cyc + lat_of(d);
          end
        end
        if (pend[d] && due[d] == cyc + 1) begin
          exp_rrdy[d]  = 1'b1;
          exp_rdata[d] = pval[d];
          pend[d]      = 1'b0;
        end
        exp_busy[d] = pend[d];
      end
    end
    cyc++;
  endtask

  task automatic compare_all();
    for (int d = 0; d < ND; d++) begin
      check($sformatf("d%0d_ack", d),   32'(ack_a[d]),  areset ? 32'd0 : 32'(exp_ack[d]));
      check($sformatf("d%0d_rrdy", d),  32'(rrdy_a[d]), areset ? 32'd0 : 32'(exp_rrdy[d]));
      check($sformatf("d%0d_busy", d),  32'(busy_a[d]), areset ? 32'd0 : 32'(exp_busy[d]));
      check($sformatf("d%0d_rdata", d), rdata_a[d],     areset ? 32'd0 : exp_rdata[d]);
    end
  endtask

  task automatic cycle();
    @(negedge aclk);
    compare_all();
    @(posedge aclk);
    model_step();
    #1;
  endtask

  // Presents a request and holds it until the model accepts it.
  task automatic issue(int d, bit w, logic [3:0] c, logic [31:0] a, logic [31:0] dat);
    int n = 0;
    cen_a[d] = c; wr_a[d] = w; addr_a[d] = a; wdata_a[d] = dat;
    do begin
      cycle();
      n++;
    end while (!acc[d] && n < 64);
    if (!acc[d]) check($sformatf("d%0d_accept_wait", d), 32'(acc[d]), 32'd1);
    cen_a[d] = CEN_IDLE;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int r;
    logic [31:0] ra;
    logic [3:0]  ri;
    for (int d = 0; d < ND; d++) begin
      cen_a[d] = CEN_IDLE; wr_a[d] = 1'b0; addr_a[d] = '0; wdata_a[d] = '0;
    end

    // Reset for 3 cycles, then idle for 5.
    repeat (3) cycle();
    areset = 1'b0;
    repeat (5) cycle();
    check("idle_ack",   32'(ack_a[0]),  32'd0);
    check("idle_rrdy",  32'(rrdy_a[0]), 32'd0);
    check("idle_busy",  32'(busy_a[1]), 32'd0);
    check("idle_rdata", rdata_a[2],     32'd0);

    // Known contents for words 0..15 of every instance.
    for (int i = 0; i < 16; i++)
      for (int d = 0; d < ND; d++)
        issue(d, 1'b1, 4'h0, 32'(i * 4), 32'hC0DE_0000 | 32'(d << 8) | 32'(i));
    repeat (4) cycle();

    // Write then read the same word back-to-back.
    issue(0, 1'b1, 4'h0, 32'h40, 32'hDEAD_BEEF);
    issue(0, 1'b0, 4'h0, 32'h40, 32'h0);
    check("raw_model", exp_rdata[0], 32'hDEAD_BEEF);
    check("raw_rdata", rdata_a[0],   32'hDEAD_BEEF);
    check("raw_rrdy",  32'(rrdy_a[0]), 32'd1);
    check("raw_ack",   32'(ack_a[0]),  32'd1);
    cycle();

    // Partial byte-lane write.
    issue(0, 1'b1, 4'h0, 32'h8, 32'h1122_3344);
    issue(0, 1'b1, 4'b1010, 32'h8, 32'hAABB_CCDD);
    issue(0, 1'b0, 4'hF ^ 4'h1, 32'h8, 32'h0);
    check("lane_model", exp_rdata[0], 32'h11BB_33DD);
    check("lane_rdata", rdata_a[0],   32'h11BB_33DD);
    cycle();

    // Latency 4: held second read accepted in the first read's response cycle.
    issue(1, 1'b0, 4'h0, 32'h0, 32'h0);
    t0 = cyc;
    check("lat4_ack",  32'(ack_a[1]),  32'd1);
    check("lat4_busy", 32'(busy_a[1]), 32'd1);
    issue(1, 1'b0, 4'h0, 32'h4, 32'h0);
    check("lat4_accept_gap", 32'(cyc - t0), 32'd4);
    check("lat4_rdata_hold", rdata_a[1], 32'hC0DE_0100);
    check("lat4_ack2", 32'(ack_a[1]), 32'd1);
    repeat (3) cycle();
    check("lat4_rrdy2",  32'(rrdy_a[1]), 32'd1);
    check("lat4_rdata2", rdata_a[1],     32'hC0DE_0101);
    cycle();

    // Address aliasing above the word-index bits.
    issue(0, 1'b1, 4'h0, 32'h1000, 32'h5);
    issue(0, 1'b0, 4'h0, 32'h0, 32'h0);
    check("alias_model", exp_rdata[0], 32'h5);
    check("alias_rdata", rdata_a[0],   32'h5);
    cycle();

    // Reset while a latency-3 read is pending.
    issue(2, 1'b0, 4'h0, 32'h4, 32'h0);
    cycle();
    areset = 1'b1;
    repeat (2) cycle();
    areset = 1'b0;
    check("rst_busy",  32'(busy_a[2]), 32'd0);
    check("rst_rrdy",  32'(rrdy_a[2]), 32'd0);
    check("rst_rdata", rdata_a[2],     32'd0);
    repeat (4) cycle();
    issue(2, 1'b0, 4'h0, 32'h8, 32'h0);
    repeat (2) cycle();
    check("post_rst_rrdy",  32'(rrdy_a[2]), 32'd1);
    check("post_rst_rdata", rdata_a[2],     32'hC0DE_0202);
    cycle();

    // Random traffic on all instances, words 0..15 with random alias bits.
    for (int k = 0; k < 800; k++) begin
      for (int d = 0; d < ND; d++) begin
        if (cen_a[d] == CEN_IDLE || acc[d]) begin
          r  = int'($urandom_range(0, 9));
          ra = $urandom();
          ri = 4'($urandom_range(0, 15));
          addr_a[d]  = {ra[31:12], 6'b0, ri, ra[1:0]};
          wdata_a[d] = $urandom();
          if (r < 3) begin
            cen_a[d] = CEN_IDLE; wr_a[d] = ra[2];
          end else if (r < 6) begin
            cen_a[d] = 4'($urandom_range(0, 15)); wr_a[d] = 1'b1;
          end else begin
            cen_a[d] = 4'($urandom_range(0, 14)); wr_a[d] = 1'b0;
          end
        end
      end
      cycle();
    end
    for (int d = 0; d < ND; d++) cen_a[d] = CEN_IDLE;
    repeat (6) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
